// File: rtl/la_rstseq_pkg.sv
// Shared types and helpers for the reset release sequencer.
//   state_e   : FSM state encoding (2-bit).
//   idx_width : width of the stage index for a given stage count (minimum 1).
package la_rstseq_pkg;

  typedef enum logic [1:0] {
    StHold = 2'b00,
    StWait = 2'b01,
    StAckw = 2'b10,
    StDone = 2'b11
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_rstseq_timer.sv
// Inter-release delay counter.
//   clk    : clock
//   nreset : asynchronous active-low reset (count returns to 0)
//   clr    : synchronous clear, wins over en
//   en     : count enable; wraps to 0 after reaching DELAY-1
//   tc     : terminal count flag, high while the count equals DELAY-1
module la_rstseq_timer #(
  parameter int unsigned CW    = 8,
  parameter int unsigned DELAY = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(DELAY - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/la_rstseq.sv
// Reset release sequencer: releases N active-low reset domains one at a time in
// index order, DELAY cycles apart, optionally waiting for a per-stage ack.
//   clk      : clock
//   nreset   : asynchronous active-low reset, already synchronized upstream
//   swrst    : synchronous software reset request (level, active high)
//   ack      : per-domain ready; only the bit of the current stage is looked at
//   nrst_out : active-low domain resets, bit k released k-th
//   done     : all domains released and all enabled acks seen
//   busy     : inverse of done
module la_rstseq
  import la_rstseq_pkg::*;
#(
  parameter int unsigned   N     = 4,
  parameter int unsigned   CW    = 8,
  parameter int unsigned   DELAY = 16,
  parameter logic [N-1:0]  ACKEN = '0
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         swrst,
  input  logic [N-1:0] ack,
  output logic [N-1:0] nrst_out,
  output logic         done,
  output logic         busy
);

  localparam int unsigned KW = idx_width(N);

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   nrst_q, nrst_d;
  logic           done_q, done_d;
  logic           tmr_clr, tmr_en, tc;

  logic [N-1:0]   k_onehot;
  logic           cur_acken, cur_ack, last;

  la_rstseq_timer #(
    .CW    (CW),
    .DELAY (DELAY)
  ) u_timer (
    .clk    (clk),
    .nreset (nreset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .tc     (tc)
  );

  // Decode the stage index by comparison so N=1 needs no zero-width select.
  always_comb begin
    k_onehot  = '0;
    cur_acken = 1'b0;
    cur_ack   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        k_onehot[i] = 1'b1;
        cur_acken   = ACKEN[i];
        cur_ack     = ack[i];
      end
    end
  end

  assign last = (k_q == KW'(N - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    nrst_d  = nrst_q;
    done_d  = done_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    if (swrst) begin
      // Software reset overrides counting and ack waiting in every state.
      state_d = StHold;
      k_d     = '0;
      nrst_d  = '0;
      done_d  = 1'b0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        StHold: begin
          tmr_clr = 1'b1;
          state_d = StWait;
        end
        StWait: begin
          tmr_en = 1'b1;
          if (tc) begin
            nrst_d = nrst_q | k_onehot;
            if (cur_acken) begin
              state_d = StAckw;
            end else if (last) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              k_d = k_q + KW'(1);
            end
          end
        end
        StAckw: begin
          // Timer already cleared on release, so WAIT restarts from 0.
          if (cur_ack) begin
            if (last) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StWait;
              k_d     = k_q + KW'(1);
            end
          end
        end
        StDone: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StWait;
      k_q     <= '0;
      nrst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      nrst_q  <= nrst_d;
      done_q  <= done_d;
    end
  end

  assign nrst_out = nrst_q;
  assign done     = done_q;
  assign busy     = ~done_q;

endmodule

// File: tb/tb_la_rstseq.sv
// Self-checking bench for la_rstseq: directed scenarios plus a randomized run
// checked against an event-level model (released-domain count and countdown).
module tb_la_rstseq;

  localparam logic [3:0] ACKEN_B = 4'b0010;
  localparam int         DLY     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DUT a: N=4, DELAY=16, no ack gating
  logic       nreset_a, swrst_a, done_a, busy_a;
  logic [3:0] ack_a, nrst_out_a;
  // DUT b: N=4, DELAY=16, stage 1 gated on ack
  logic       nreset_b, swrst_b, done_b, busy_b;
  logic [3:0] ack_b, nrst_out_b;
  // DUT c: N=1, DELAY=1, gated on ack
  logic       nreset_c, swrst_c, done_c, busy_c;
  logic [0:0] ack_c, nrst_out_c;

  la_rstseq #(.N(4), .CW(8), .DELAY(16), .ACKEN(4'b0000)) dut_a (
    .clk(clk), .nreset(nreset_a), .swrst(swrst_a), .ack(ack_a),
    .nrst_out(nrst_out_a), .done(done_a), .busy(busy_a)
  );

  la_rstseq #(.N(4), .CW(8), .DELAY(16), .ACKEN(ACKEN_B)) dut_b (
    .clk(clk), .nreset(nreset_b), .swrst(swrst_b), .ack(ack_b),
    .nrst_out(nrst_out_b), .done(done_b), .busy(busy_b)
  );

  la_rstseq #(.N(1), .CW(4), .DELAY(1), .ACKEN(1'b1)) dut_c (
    .clk(clk), .nreset(nreset_c), .swrst(swrst_c), .ack(ack_c),
    .nrst_out(nrst_out_c), .done(done_c), .busy(busy_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pattern when the first n domains are released.
  function automatic logic [3:0] rel_mask(input int n);
    int m;
    m = (n > 4) ? 4 : n;
    return 4'((1 << m) - 1);
  endfunction

  // ---------------- reference model for DUT b ----------------
  int m_rel;    // domains released so far
  int m_left;   // edges left until the next release
  bit m_hold, m_ackw, m_done;

  task automatic m_reset();
    m_rel = 0; m_left = DLY; m_hold = 0; m_ackw = 0; m_done = 0;
  endtask

  task automatic m_edge(input logic sw, input logic [3:0] a);
    if (sw) begin
      m_rel = 0; m_hold = 1; m_ackw = 0; m_done = 0;
    end else if (m_hold) begin
      m_hold = 0; m_left = DLY;
    end else if (m_done) begin
    end else if (m_ackw) begin
      if (a[m_rel-1]) begin
        m_ackw = 0;
        if (m_rel == 4) m_done = 1;
        else m_left = DLY;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_rel++;
        if (ACKEN_B[m_rel-1]) m_ackw = 1;
        else if (m_rel == 4) m_done = 1;
        else m_left = DLY;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick();
    checks++;
    if (nrst_out_a !== 4'b0000) begin
      errors++; $display("FAIL reset_nrst_a: got %b want 0000", nrst_out_a);
    end
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL reset_done_busy_a: got %b/%b want 0/1", done_a, busy_a);
    end
    checks++;
    if (nrst_out_b !== 4'b0000 || done_b !== 1'b0) begin
      errors++; $display("FAIL reset_b: got %b/%b want 0000/0", nrst_out_b, done_b);
    end
    checks++;
    if (nrst_out_c !== 1'b0 || busy_c !== 1'b1) begin
      errors++; $display("FAIL reset_c: got %b/%b want 0/1", nrst_out_c, busy_c);
    end
  endtask

  task automatic test_plain();
    logic [3:0] exp;
    nreset_a = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick();
      exp = rel_mask(e / DLY);
      checks++;
      if (nrst_out_a !== exp) begin
        errors++; $display("FAIL plain_nrst edge %0d: got %b want %b", e, nrst_out_a, exp);
      end
      checks++;
      if (done_a !== 1'(e >= 64) || busy_a !== 1'(e < 64)) begin
        errors++;
        $display("FAIL plain_done edge %0d: got done=%b busy=%b want done=%b",
                 e, done_a, busy_a, 1'(e >= 64));
      end
    end
  endtask

  task automatic test_swrst_done();
    swrst_a = 1'b1;
    tick();
    checks++;
    if (nrst_out_a !== 4'b0000 || done_a !== 1'b0) begin
      errors++; $display("FAIL swrst_clear: got %b/%b want 0000/0", nrst_out_a, done_a);
    end
    for (int i = 0; i < 4; i++) tick();
    swrst_a = 1'b0;
    tick();  // edge sampling swrst low
    for (int i = 1; i <= DLY; i++) begin
      tick();
      checks++;
      if (nrst_out_a !== ((i == DLY) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL swrst_restart +%0d: got %b", i, nrst_out_a);
      end
    end
  endtask

  task automatic test_nreset_mid();
    nreset_a = 1'b0;
    tick();
    nreset_a = 1'b1;
    for (int e = 1; e <= 40; e++) tick();
    checks++;
    if (nrst_out_a !== 4'b0011) begin
      errors++; $display("FAIL nrst_mid_pre: got %b want 0011", nrst_out_a);
    end
    nreset_a = 1'b0;
    #1;
    checks++;
    if (nrst_out_a !== 4'b0000 || done_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL nrst_mid_async: got %b done=%b busy=%b", nrst_out_a, done_a, busy_a);
    end
    nreset_a = 1'b1;
    for (int e = 1; e <= DLY; e++) begin
      tick();
      checks++;
      if (nrst_out_a !== ((e == DLY) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL nrst_mid_restart edge %0d: got %b", e, nrst_out_a);
      end
    end
  endtask

  task automatic reset_b();
    swrst_b = 1'b0; ack_b = '0;
    nreset_b = 1'b0;
    tick();
    nreset_b = 1'b1;
  endtask

  task automatic test_ack_gate();
    reset_b();
    for (int e = 1; e <= 32; e++) begin
      if (e == 5) ack_b = 4'b0010;   // early ack for stage 1 must be ignored
      if (e == 9) ack_b = 4'b0000;
      tick();
      checks++;
      if (nrst_out_b !== rel_mask(e / DLY)) begin
        errors++; $display("FAIL ack_pre edge %0d: got %b want %b", e, nrst_out_b, rel_mask(e / DLY));
      end
    end
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (nrst_out_b !== 4'b0011 || done_b !== 1'b0) begin
      errors++; $display("FAIL ack_hold: got %b/%b want 0011/0", nrst_out_b, done_b);
    end
    ack_b = 4'b0010;
    tick();  // edge sampling the ack
    ack_b = 4'b0000;
    for (int i = 1; i <= 2 * DLY; i++) begin
      tick();
      checks++;
      if (nrst_out_b !== rel_mask(2 + i / DLY) || done_b !== 1'(i == 2 * DLY)) begin
        errors++;
        $display("FAIL ack_release +%0d: got %b/%b want %b/%b", i, nrst_out_b, done_b,
                 rel_mask(2 + i / DLY), 1'(i == 2 * DLY));
      end
    end
  endtask

  task automatic test_swrst_ack_same();
    reset_b();
    for (int e = 1; e <= 32; e++) tick();
    swrst_b = 1'b1;
    ack_b   = 4'b0010;
    tick();
    checks++;
    if (nrst_out_b !== 4'b0000 || done_b !== 1'b0) begin
      errors++; $display("FAIL swrst_ack: got %b/%b want 0000/0", nrst_out_b, done_b);
    end
    swrst_b = 1'b0;
    ack_b   = 4'b0000;
    tick();
    for (int i = 1; i <= DLY; i++) begin
      tick();
      checks++;
      if (nrst_out_b !== ((i == DLY) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL swrst_ack_restart +%0d: got %b", i, nrst_out_b);
      end
    end
  endtask

  task automatic test_single();
    nreset_c = 1'b1;
    tick();
    checks++;
    if (nrst_out_c !== 1'b1 || done_c !== 1'b0) begin
      errors++; $display("FAIL single_edge1: got %b/%b want 1/0", nrst_out_c, done_c);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done_c !== 1'b0 || busy_c !== 1'b1) begin
        errors++; $display("FAIL single_wait %0d: got done=%b busy=%b", i, done_c, busy_c);
      end
    end
    ack_c = 1'b1;
    tick();
    ack_c = 1'b0;
    checks++;
    if (done_c !== 1'b1 || busy_c !== 1'b0 || nrst_out_c !== 1'b1) begin
      errors++; $display("FAIL single_done: got done=%b busy=%b nrst=%b", done_c, busy_c, nrst_out_c);
    end
  endtask

  task automatic test_random();
    int r;
    reset_b();
    m_reset();
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 299);
      if (r == 0) begin
        nreset_b = 1'b0;
        #1;
        m_reset();
        checks++;
        if (nrst_out_b !== 4'b0000 || done_b !== 1'b0) begin
          errors++; $display("FAIL rand_async it %0d: got %b/%b", it, nrst_out_b, done_b);
        end
        nreset_b = 1'b1;
      end
      if (swrst_b) swrst_b = ($urandom_range(0, 1) == 0);
      else swrst_b = ($urandom_range(0, 59) == 0);
      ack_b = 4'($urandom) & 4'($urandom);
      tick();
      m_edge(swrst_b, ack_b);
      checks++;
      if (nrst_out_b !== rel_mask(m_rel) || done_b !== m_done || busy_b !== !m_done) begin
        errors++;
        $display("FAIL rand it %0d: got %b done=%b busy=%b want %b done=%b",
                 it, nrst_out_b, done_b, busy_b, rel_mask(m_rel), m_done);
      end
    end
  endtask

  initial begin
    nreset_a = 1'b0; swrst_a = 1'b0; ack_a = '0;
    nreset_b = 1'b0; swrst_b = 1'b0; ack_b = '0;
    nreset_c = 1'b0; swrst_c = 1'b0; ack_c = '0;
    test_reset();
    test_plain();
    test_swrst_done();
    test_nreset_mid();
    test_ack_gate();
    test_swrst_ack_same();
    test_single();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
